mux_tree_pipe: RTL
==================

MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 64, number of input channels; power of two, 2..64.
REQ-002 SHALL have parameter DW, default 1, per-channel data width; 1..32.
REQ-003 SHALL have parameter PIPE_EVERY, default 2, number of 2:1 tree levels per register stage; 1..6.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream offers a word.
REQ-007 SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-008 SHALL have port in_data  input  N_IN*DW  channel k occupies bits [k*DW +: DW].
REQ-009 SHALL have port in_sel  input  SW=log2(N_IN)  channel select, sampled with in_data.
REQ-010 SHALL have port out_valid  output  1  out_data/out_sel hold a selected word.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the word.
REQ-012 SHALL have port out_data  output  DW  selected channel data.
REQ-013 SHALL have port out_sel  output  SW  in_sel value that produced out_data.
REQ-014 SHALL have port xfer_cnt  output  16  output transfer count (see Configuration).

Function
REQ-015 SHALL implement a binary 2:1 tree of L=log2(N_IN) levels; level i is steered by select bit i; sel bit 0 steers the leaf level.
REQ-016 SHALL insert a register stage after every PIPE_EVERY levels and after the final level; stage count S=ceil(L/PIPE_EVERY).
REQ-017 Each stage SHALL hold a valid bit, partial data and the remaining unconsumed select bits.
REQ-018 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-019 Latency SHALL be exactly S cycles from input transfer to out_valid with out_ready held high.
REQ-020 Throughput SHALL be one word per cycle when out_ready is held high.
REQ-021 Stage j SHALL load when it is empty or its contents advance this cycle (bubble-collapsing); in_ready = stage-0 empty or stage 0 advancing.
REQ-022 in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 With out_ready low, out_valid, out_data and out_sel SHALL hold stable; the pipe fills to S words, then in_ready drops.
REQ-024 Simultaneous output and input transfer with a full pipe SHALL lose no word and duplicate no word.
REQ-025 Words SHALL leave in acceptance order.
REQ-026 out_data and out_sel SHALL be stable while out_valid is low and SHALL never be X after reset.

Reset
REQ-027 rst_n low SHALL asynchronously clear all stage valid bits, data and select registers to 0.
REQ-028 During and after reset: out_valid=0, out_data=0, out_sel=0, xfer_cnt=0; in_ready=1 from the first clk edge after rst_n rises.
REQ-029 Reset mid-operation SHALL discard all in-flight words; none may appear after release.

Configuration
REQ-030 Macro MUX_TREE_XFER_CNT_EN defined: xfer_cnt SHALL increment by 1 per output transfer, saturate at 16'hFFFF and clear on reset.
REQ-031 Macro MUX_TREE_XFER_CNT_EN undefined: xfer_cnt SHALL be constant 0 and no counter flops SHALL be built; all other behaviour identical.

Verification (N_IN=64, DW=8, PIPE_EVERY=2, S=3)
REQ-032 Channel k = 8'(k+1); stream in_sel 0..63 back-to-back, out_ready=1 -> out_data 1..64 on consecutive cycles starting 3 cycles after the first accept; out_sel echoes 0..63.
REQ-033 Accept sel=63 then out_ready=0 for 10 cycles while offering sel=5,6,7 -> in_ready low after 3 accepts; out_data holds 64 stable; release yields 64, 6, 7, 8 in order, nothing dropped.
REQ-034 Alternate out_ready 1/0 every cycle with continuous in_valid over 200 random sels -> scoreboard matches exactly; output words equal accepted words.
REQ-035 Assert rst_n low with 3 words in flight -> out_valid=0 immediately; after release no stale word appears; first new word appears after 3 cycles.
REQ-036 With MUX_TREE_XFER_CNT_EN: 70000 transfers -> xfer_cnt=16'hFFFF; reset -> 0. Without the macro: xfer_cnt=0 throughout.
REQ-037 Repeat REQ-032 with N_IN=2, DW=1, PIPE_EVERY=1 and with N_IN=64, PIPE_EVERY=6 -> latency 1 cycle in both cases; data correct.

Source files
------------

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_pipe
// Description : Pipelined N_IN:1 binary mux tree with valid/ready flow control.
//               A register stage follows every PIPE_EVERY levels and the last.
//               Optional output-transfer counter: MUX_TREE_XFER_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_pipe #(
    parameter int N_IN       = 64,
    parameter int DW         = 1,
    parameter int PIPE_EVERY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*DW-1:0]      in_data,
    input  logic [$clog2(N_IN)-1:0] in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(N_IN)-1:0] out_sel,
    output logic [15:0]             xfer_cnt
);

    localparam int c_sw     = $clog2(N_IN);
    localparam int c_stages = (c_sw + PIPE_EVERY - 1) / PIPE_EVERY;

    generate
        for (genvar j = 0; j < c_stages; j++) begin : g_stage
            localparam int c_lin  = j * PIPE_EVERY;
            localparam int c_lout = (c_lin + PIPE_EVERY > c_sw) ? c_sw : c_lin + PIPE_EVERY;
            localparam int c_nlv  = c_lout - c_lin;
            localparam int c_win  = (N_IN >> c_lin) * DW;
            localparam int c_wout = (N_IN >> c_lout) * DW;

            logic              w_vin;
            logic [c_win-1:0]  w_din;
            logic [c_sw-1:0]   w_sin;
            logic              w_ld;
            logic              r_valid;
            logic [c_wout-1:0] r_data;
            logic [c_sw-1:0]   r_sel;

            if (j == 0) begin : g_src_port
                assign w_vin = in_valid;
                assign w_din = in_data;
                assign w_sin = in_sel;
            end else begin : g_src_stage
                assign w_vin = g_stage[j-1].r_valid;
                assign w_din = g_stage[j-1].r_data;
                assign w_sin = g_stage[j-1].r_sel;
            end

            // A stage accepts when empty or when its current word moves on.
            if (j == c_stages - 1) begin : g_ld_last
                assign w_ld = !r_valid || out_ready;
            end else begin : g_ld_mid
                assign w_ld = !r_valid || g_stage[j+1].w_ld;
            end

            for (genvar k = 0; k < c_nlv; k++) begin : g_lvl
                localparam int c_nodes = N_IN >> (c_lin + k + 1);

                logic [c_nodes*DW-1:0]   w_lv;
                logic [2*c_nodes*DW-1:0] w_src;

                if (k == 0) begin : g_first
                    assign w_src = w_din;
                end else begin : g_next
                    assign w_src = g_lvl[k-1].w_lv;
                end

                for (genvar n = 0; n < c_nodes; n++) begin : g_node
                    assign w_lv[n*DW +: DW] = w_sin[c_lin+k] ? w_src[(2*n+1)*DW +: DW]
                                                             : w_src[2*n*DW +: DW];
                end
            end

            // Payload only changes on a valid load, so outputs hold through bubbles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_sel   <= '0;
                end else if (w_ld) begin
                    r_valid <= w_vin;
                    if (w_vin) begin
                        r_data <= g_lvl[c_nlv-1].w_lv;
                        r_sel  <= w_sin;
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = g_stage[0].w_ld;
    assign out_valid = g_stage[c_stages-1].r_valid;
    assign out_data  = g_stage[c_stages-1].r_data;
    assign out_sel   = g_stage[c_stages-1].r_sel;

`ifdef MUX_TREE_XFER_CNT_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= 16'h0000;
        end else if (out_valid && out_ready && (r_xfer_cnt != 16'hFFFF)) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`else
    assign xfer_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
